// File: rtl/rsv_pkg.sv
// +--------------------------------------------------------------------+
// | rsv_pkg : shared opcode/funct3 constants and entry control struct  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package rsv_pkg;

  localparam int RSV_TAG_WIDTH = 4;

  localparam logic [6:0] R_type   = 7'b0110011;
  localparam logic [6:0] I_type_1 = 7'b0000011;
  localparam logic [6:0] I_type_2 = 7'b0010011;
  localparam logic [6:0] S_type   = 7'b0100011;
  localparam logic [6:0] B_type   = 7'b1100011;
  localparam logic [6:0] U_type   = 7'b0110111;
  localparam logic [6:0] J_type   = 7'b1101111;

  localparam logic [5:0] F3_ADD_SUB = 6'd0;
  localparam logic [5:0] F3_SLL     = 6'd1;
  localparam logic [5:0] F3_SLT     = 6'd2;
  localparam logic [5:0] F3_SLTU    = 6'd3;
  localparam logic [5:0] F3_XOR     = 6'd4;
  localparam logic [5:0] F3_SRL_SRA = 6'd5;
  localparam logic [5:0] F3_OR      = 6'd6;
  localparam logic [5:0] F3_AND     = 6'd7;

  // Per-entry control fields, forwarded untouched to the ALU on issue.
  typedef struct packed {
    logic [6:0] opcode;
    logic [5:0] funct3;
    logic [6:0] funct7;
    logic [4:0] imm5;
    logic [6:0] imm_funct;
  } rsv_ctrl_t;

endpackage

`default_nettype wire

// File: rtl/rsv_age_select.sv
// +--------------------------------------------------------------------+
// | rsv_age_select : age-matrix picker, one-hot grant of oldest req    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module rsv_age_select
  import rsv_pkg::*;
#(
  parameter int ENTRIES = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               flush,
  input  logic [ENTRIES-1:0] alloc,
  input  logic [ENTRIES-1:0] req,
  output logic [ENTRIES-1:0] grant
);

  localparam logic [ENTRIES-1:0] ONE = ENTRIES'(1);

  // older[i][j] set means entry i was allocated before entry j.
  logic [ENTRIES-1:0] older [ENTRIES];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < ENTRIES; i++) older[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) older[i] <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (alloc[i]) older[i] <= '0;
        else          older[i] <= older[i] | alloc;
      end
    end
  end

  for (genvar i = 0; i < ENTRIES; i++) begin : g_grant
    assign grant[i] = req[i] & ~|(req & ~older[i] & ~(ONE << i));
  end

endmodule

`default_nettype wire

// File: rtl/alu_rsv_station.sv
// +--------------------------------------------------------------------+
// | alu_rsv_station : integer ALU reservation station, CDB wakeup,     |
// | oldest-ready registered issue. Option macro: RS_CDB_BYPASS_EN      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module alu_rsv_station
  import rsv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ENTRIES    = 4,
  parameter int TAG_WIDTH  = RSV_TAG_WIDTH
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         flush,
  input  logic                         disp_valid,
  output logic                         disp_ready,
  input  logic [6:0]                   disp_opcode,
  input  logic [5:0]                   disp_funct3,
  input  logic [6:0]                   disp_funct7,
  input  logic [4:0]                   disp_imm5,
  input  logic [6:0]                   disp_imm_funct,
  input  logic [TAG_WIDTH-1:0]         disp_dst_tag,
  input  logic                         disp_src1_rdy,
  input  logic                         disp_src2_rdy,
  input  logic [DATA_WIDTH-1:0]        disp_src1_val,
  input  logic [DATA_WIDTH-1:0]        disp_src2_val,
  input  logic [TAG_WIDTH-1:0]         disp_src1_tag,
  input  logic [TAG_WIDTH-1:0]         disp_src2_tag,
  input  logic                         cdb_valid,
  input  logic [TAG_WIDTH-1:0]         cdb_tag,
  input  logic [DATA_WIDTH-1:0]        cdb_data,
  input  logic                         issue_ready,
  output logic [6:0]                   opcode,
  output logic [5:0]                   funct3,
  output logic [6:0]                   funct7,
  output logic [4:0]                   reduced_Imm,
  output logic [6:0]                   Imm_funct,
  output logic [DATA_WIDTH-1:0]        BusWires1,
  output logic [DATA_WIDTH-1:0]        BusWires2,
  output logic                         data_out_valid,
  output logic [TAG_WIDTH-1:0]         issue_tag,
  output logic [$clog2(ENTRIES+1)-1:0] occupancy
);

  localparam int               OCC_W    = $clog2(ENTRIES + 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(ENTRIES);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);

  logic [ENTRIES-1:0]    valid, s1_rdy, s2_rdy;
  rsv_ctrl_t             ctrl   [ENTRIES];
  logic [TAG_WIDTH-1:0]  dst    [ENTRIES];
  logic [TAG_WIDTH-1:0]  s1_tag [ENTRIES];
  logic [TAG_WIDTH-1:0]  s2_tag [ENTRIES];
  logic [DATA_WIDTH-1:0] s1_val [ENTRIES];
  logic [DATA_WIDTH-1:0] s2_val [ENTRIES];
  logic [OCC_W-1:0]      occ;

  logic [ENTRIES-1:0]    wake1, wake2, cand, grant, free_oh, alloc;
  logic                  accept, do_issue, found;
  logic                  d1_rdy, d2_rdy;
  logic [DATA_WIDTH-1:0] d1_val, d2_val;
  rsv_ctrl_t             disp_ctrl, sel_ctrl;
  logic [TAG_WIDTH-1:0]  sel_tag;
  logic [DATA_WIDTH-1:0] sel_op1, sel_op2;

  assign disp_ready = (occ != OCC_FULL);
  assign occupancy  = occ;
  assign accept     = disp_valid & disp_ready & ~flush;
  assign do_issue   = issue_ready & (|cand) & ~flush;
  assign alloc      = accept ? free_oh : '0;

  always_comb begin
    disp_ctrl.opcode    = disp_opcode;
    disp_ctrl.funct3    = disp_funct3;
    disp_ctrl.funct7    = disp_funct7;
    disp_ctrl.imm5      = disp_imm5;
    disp_ctrl.imm_funct = disp_imm_funct;
    // A producer broadcasting in the dispatch cycle must not be missed.
    d1_rdy = disp_src1_rdy | (cdb_valid & (cdb_tag == disp_src1_tag));
    d2_rdy = disp_src2_rdy | (cdb_valid & (cdb_tag == disp_src2_tag));
    d1_val = disp_src1_rdy ? disp_src1_val : cdb_data;
    d2_val = disp_src2_rdy ? disp_src2_val : cdb_data;
  end

  always_comb begin
    free_oh = '0;
    found   = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      wake1[i] = valid[i] & ~s1_rdy[i] & cdb_valid & (cdb_tag == s1_tag[i]);
      wake2[i] = valid[i] & ~s2_rdy[i] & cdb_valid & (cdb_tag == s2_tag[i]);
      if (!valid[i] && !found) begin
        free_oh[i] = 1'b1;
        found      = 1'b1;
      end
    end
`ifdef RS_CDB_BYPASS_EN
    cand = valid & (s1_rdy | wake1) & (s2_rdy | wake2);
`else
    cand = valid & s1_rdy & s2_rdy;
`endif
  end

  rsv_age_select #(
    .ENTRIES (ENTRIES)
  ) u_age_select (
    .clk    (clk),
    .resetn (resetn),
    .flush  (flush),
    .alloc  (alloc),
    .req    (cand),
    .grant  (grant)
  );

  always_comb begin
    sel_ctrl = '0;
    sel_tag  = '0;
    sel_op1  = '0;
    sel_op2  = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (grant[i]) begin
        sel_ctrl = ctrl[i];
        sel_tag  = dst[i];
`ifdef RS_CDB_BYPASS_EN
        sel_op1  = s1_rdy[i] ? s1_val[i] : cdb_data;
        sel_op2  = s2_rdy[i] ? s2_val[i] : cdb_data;
`else
        sel_op1  = s1_val[i];
        sel_op2  = s2_val[i];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid  <= '0;
      s1_rdy <= '0;
      s2_rdy <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctrl[i]   <= '0;
        dst[i]    <= '0;
        s1_tag[i] <= '0;
        s2_tag[i] <= '0;
        s1_val[i] <= '0;
        s2_val[i] <= '0;
      end
    end else if (flush) begin
      valid <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (alloc[i]) begin
          valid[i]  <= 1'b1;
          ctrl[i]   <= disp_ctrl;
          dst[i]    <= disp_dst_tag;
          s1_rdy[i] <= d1_rdy;
          s2_rdy[i] <= d2_rdy;
          s1_val[i] <= d1_val;
          s2_val[i] <= d2_val;
          s1_tag[i] <= disp_src1_tag;
          s2_tag[i] <= disp_src2_tag;
        end else begin
          if (do_issue && grant[i]) valid[i] <= 1'b0;
          if (wake1[i]) begin
            s1_rdy[i] <= 1'b1;
            s1_val[i] <= cdb_data;
          end
          if (wake2[i]) begin
            s2_rdy[i] <= 1'b1;
            s2_val[i] <= cdb_data;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      occ <= '0;
    end else if (flush) begin
      occ <= '0;
    end else if (accept && !do_issue) begin
      occ <= occ + OCC_ONE;
    end else if (!accept && do_issue) begin
      occ <= occ - OCC_ONE;
    end
  end

  // Control/operand outputs hold their last issued values when idle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_out_valid <= 1'b0;
      opcode         <= '0;
      funct3         <= '0;
      funct7         <= '0;
      reduced_Imm    <= '0;
      Imm_funct      <= '0;
      BusWires1      <= '0;
      BusWires2      <= '0;
      issue_tag      <= '0;
    end else if (do_issue) begin
      data_out_valid <= 1'b1;
      opcode         <= sel_ctrl.opcode;
      funct3         <= sel_ctrl.funct3;
      funct7         <= sel_ctrl.funct7;
      reduced_Imm    <= sel_ctrl.imm5;
      Imm_funct      <= sel_ctrl.imm_funct;
      BusWires1      <= sel_op1;
      BusWires2      <= sel_op2;
      issue_tag      <= sel_tag;
    end else begin
      data_out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: doc/alu_rsv_station.md
Name: alu_rsv_station

Overview:
- Reservation station sitting directly upstream of the integer ALU in the out-of-order pipeline.
- Accepts decoded integer ops from dispatch and holds them until both operands are available.
- Snoops the common data bus (CDB) for missing operands.
- Issues the oldest ready op per cycle on the ALU's operand/control interface, qualified by data_out_valid.

Parameters:
- DATA_WIDTH, 32, operand width.
- ENTRIES, 4, number of station slots (2..16).
- TAG_WIDTH, 4, physical/ROB tag width.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of all entries.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  at least one free slot.
- disp_opcode  in  7  opcode.
- disp_funct3  in  6  funct3 field.
- disp_funct7  in  7  funct7 field.
- disp_imm5  in  5  shift immediate.
- disp_imm_funct  in  7  immediate funct bits.
- disp_dst_tag  in  TAG_WIDTH  result tag.
- disp_src1_rdy, disp_src2_rdy  in  1  operand already valid.
- disp_src1_val, disp_src2_val  in  DATA_WIDTH  operand value.
- disp_src1_tag, disp_src2_tag  in  TAG_WIDTH  producer tag when not ready.
- cdb_valid  in  1  broadcast valid.
- cdb_tag  in  TAG_WIDTH  broadcast tag.
- cdb_data  in  DATA_WIDTH  broadcast value.
- issue_ready  in  1  ALU can accept (tie 1 for the single-cycle ALU).
- opcode, funct3, funct7, reduced_Imm, Imm_funct  out  7/6/7/5/7  issued control fields.
- BusWires1, BusWires2  out  DATA_WIDTH  issued operands.
- data_out_valid  out  1  issue strobe to ALU.
- issue_tag  out  TAG_WIDTH  dst tag of issued op.
- occupancy  out  $clog2(ENTRIES+1)  valid entry count.

Behaviour:
- Reset (async, resetn=0): all entry valid bits clear, age matrix clear, every output 0, disp_ready=1 once released.
- Entry fields: valid, op fields, dst tag, and per source rdy/val/tag.
- Dispatch: when disp_valid && disp_ready, allocate the lowest-index free slot at the clock edge.
  - disp_ready is derived from registered occupancy only; a slot freed by issue in the same cycle is not reusable until the next cycle.
- Dispatch-time CDB capture: if a source is not ready and cdb_valid && cdb_tag matches its tag in the same cycle, the slot is written ready with cdb_data.
- Wakeup: each cycle every valid entry compares its not-ready source tags against the CDB; on a match it latches cdb_data and sets rdy. Both sources may wake on the same broadcast.
- Select: candidates are valid entries with both rdy bits set in registered state. Pick the oldest using an ENTRIES x ENTRIES age matrix; a newly dispatched entry is younger than all present entries.
- Issue is registered:
  - If issue_ready and a candidate exists at edge N, outputs carry that entry's fields from N+1 and data_out_valid=1 for exactly that cycle.
  - The slot is freed at edge N.
  - With no issue, data_out_valid=0 and the other outputs hold their last values.
- Latency: dispatch with both operands ready issues at earliest 1 cycle after acceptance (data_out_valid in the 2nd cycle after the dispatch edge).
- issue_ready=0: no select and no free; entries retain state.
- Simultaneous dispatch, wakeup, issue and flush: flush wins. All valid bits clear, the dispatch is dropped, and data_out_valid=0 next cycle.
- Full (occupancy==ENTRIES): disp_ready=0 and disp_valid is ignored.
- Empty: data_out_valid stays 0.
- occupancy: +1 on accepted dispatch, −1 on issue, net 0 when both occur.
- Reset mid-operation discards all entries immediately.

Optional Feature:
- Macro: RS_CDB_BYPASS_EN.
- Defined: an entry whose last missing operand matches the CDB this cycle is a select candidate in the same cycle, with cdb_data muxed straight into BusWires1/2. This saves one cycle of wakeup-to-issue.
- Undefined: the woken entry becomes a candidate only in the cycle after capture.

Decomposition:
- Shared package rsv_pkg:
  - opcode constants (R_type, I_type_2, B_type, U_type, ...).
  - funct3 constants.
  - entry typedef struct.
  - TAG_WIDTH default.
- One sub-module: rsv_age_select, the age-matrix oldest-ready picker producing a one-hot grant.

Test Plan:
- Dispatch ADD with both sources ready (5, 7), issue_ready=1 -> data_out_valid=1 two cycles after disp_valid, BusWires1=5, BusWires2=7, issue_tag=disp_dst_tag, occupancy back to 0.
- Dispatch src1 pending on tag 3, then cdb_valid with tag 3 and data 0x1234 two cycles later -> BusWires1=0x1234, issue one cycle after broadcast (same cycle with RS_CDB_BYPASS_EN).
- Fill 4 entries all waiting on tag 9 -> disp_ready=0. Broadcast tag 9 -> issue in dispatch order over 4 consecutive cycles, disp_ready=1 after the first issue edge.
- CDB tag matches disp_src2_tag in the same cycle as dispatch -> captured, no deadlock, op issues.
- flush asserted with 3 valid entries plus a concurrent dispatch -> occupancy=0, no data_out_valid next cycle.
- resetn low mid-stream -> all outputs 0 asynchronously, then normal dispatch works after release.
